// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IF/LS arbiter and sequencer for the single memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: LS over IF).
module mem_port_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [63:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_resp_valid,
  output logic [63:0] ls_rdata,
  output logic [63:0] mem_raddr,
  output logic        mem_read,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_write,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        win_ls;
  logic        lat_we;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [7:0]  lat_wmask;
  logic [63:0] if_rdata_q;
  logic [63:0] ls_rdata_q;
  logic        ls_pri;
  logic        grant_ls;
  logic        accept;
  logic        strobe;

`ifdef MEM_ARB_RR_EN
  logic last_ls;

  always_ff @(posedge clk) begin
    if (!rst_n) last_ls <= 1'b0;
    else if (accept) last_ls <= grant_ls;
  end

  assign ls_pri = ~last_ls;
`else
  assign ls_pri = 1'b1;
`endif

  assign grant_ls = ls_req_valid & (~if_req_valid | ls_pri);
  assign accept   = if_req_ready | ls_req_ready;
  assign strobe   = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and responses are gated by rst_n so a reset abandons cleanly.
  always_comb begin
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    busy          = (state != IDLE);
    unique case (1'b1)
      (state == IDLE): begin
        if_req_ready = rst_n & if_req_valid & ~grant_ls;
        ls_req_ready = rst_n & grant_ls;
      end
      (state == ACCESS): begin
        mem_read  = rst_n & strobe & ~lat_we;
        mem_write = rst_n & strobe & lat_we;
      end
      (state == RESP): begin
        if_resp_valid = rst_n & ~win_ls;
        ls_resp_valid = rst_n & win_ls;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      win_ls     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 64'd0;
      lat_wdata  <= 64'd0;
      lat_wmask  <= 8'd0;
      if_rdata_q <= 64'd0;
      ls_rdata_q <= 64'd0;
    end else begin
      if (accept) begin
        cnt       <= CNT_INIT;
        win_ls    <= grant_ls;
        lat_we    <= grant_ls & ls_we;
        lat_addr  <= grant_ls ? ls_addr : if_addr;
        lat_wdata <= grant_ls ? ls_wdata : 64'd0;
        lat_wmask <= grant_ls ? ls_wmask : 8'd0;
      end else if ((state == ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (strobe && !lat_we) begin
        if (win_ls) ls_rdata_q <= mem_rdata;
        else if_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_raddr = lat_addr;
  assign mem_waddr = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_wmask = lat_wmask;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter.
// Honours MEM_ARB_RR_EN for the arbitration reference.
module tb_mem_port_arbiter;

  localparam int LAT = 3;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_resp_valid;
  logic [63:0] if_rdata;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic        ls_we = 1'b0;
  logic [63:0] ls_addr = '0;
  logic [63:0] ls_wdata = '0;
  logic [7:0]  ls_wmask = '0;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;
  logic [63:0] mem_raddr;
  logic        mem_read;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_write;
  logic [63:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_resp_valid(if_resp_valid),
    .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_resp_valid(ls_resp_valid),
    .ls_rdata(ls_rdata),
    .mem_raddr(mem_raddr), .mem_read(mem_read),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [63:0] init_val(input int i);
    if (i == 0) return 64'h0000_0000_0010_0073;
    return {32'hC0DE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i) * 32'h1111};
  endfunction

  // Memory blackbox seen by the DUT
  logic [63:0] sim_mem [16];
  assign mem_rdata = sim_mem[mem_raddr[6:3]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) sim_mem[i] <= init_val(i);
    end else if (mem_write) begin
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b])
          sim_mem[mem_waddr[6:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    bit          ls;
    bit          we;
    logic [63:0] rdata;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ref_mem [16];
  logic [63:0] last_if = '0;
  logic [63:0] last_ls = '0;
  bit          model_last_ls = 1'b0;
  bit          refill_en = 1'b1;

  bit          if_pend = 0, ls_pend = 0, ls_we_v = 0;
  logic [63:0] if_a = '0, ls_a = '0, ls_wd = '0;
  logic [7:0]  ls_wm = '0;

  function automatic bit ls_pri();
`ifdef MEM_ARB_RR_EN
    return !model_last_ls;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] rand_addr();
    return BASE | 64'($urandom_range(0, 127));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    last_if = '0;
    last_ls = '0;
    model_last_ls = 1'b0;
  endtask

  task automatic new_if();
    if_pend = 1;
    if_a = rand_addr();
  endtask

  task automatic new_ls();
    ls_pend = 1;
    ls_we_v = 1'($urandom_range(0, 1));
    ls_a = rand_addr();
    ls_wd = {$urandom, $urandom};
    ls_wm = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic drive_inputs();
    if_req_valid = if_pend;
    if_addr = if_a;
    ls_req_valid = ls_pend;
    ls_we = ls_we_v;
    ls_addr = ls_a;
    ls_wdata = ls_wd;
    ls_wmask = ls_wm;
  endtask

  task automatic refill();
    if (refill_en) begin
      if (!if_pend && $urandom_range(0, 2) != 0) new_if();
      if (!ls_pend && $urandom_range(0, 2) != 0) new_ls();
    end
    drive_inputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_if_ready"}, if_req_ready, 0);
    chk({tag, "_ls_ready"}, ls_req_ready, 0);
    chk({tag, "_strobes"}, {mem_read, mem_write}, 0);
    chk({tag, "_resps"}, {if_resp_valid, ls_resp_valid}, 0);
    chk({tag, "_raddr"}, mem_raddr, 0);
    chk({tag, "_waddr"}, mem_waddr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wmask"}, mem_wmask, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ls_rdata"}, ls_rdata, 0);
  endtask

  // Called at the negedge of the accept cycle; returns at the next idle cycle.
  task automatic run_txn(input bit is_ls);
    exp_t        e;
    bit          we;
    logic [63:0] a, wd;
    logic [7:0]  wm;
    int          idx;
    we  = is_ls && ls_we_v;
    a   = is_ls ? ls_a : if_a;
    wd  = is_ls ? ls_wd : 64'd0;
    wm  = is_ls ? ls_wm : 8'd0;
    idx = int'(a[6:3]);
    e.ls = is_ls;
    e.we = we;
    e.acc = cyc;
    e.rdata = ref_mem[idx];
    if (we)
      for (int b = 0; b < 8; b++)
        if (wm[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
    q.push_back(e);
    model_last_ls = is_ls;
    @(posedge clk); #1;
    if (is_ls) ls_pend = 0;
    else if_pend = 0;
    if (refill_en && $urandom_range(0, 1) == 1) begin
      if (!if_pend) new_if();
      else if (!ls_pend) new_ls();
    end
    drive_inputs();
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("if_ready_busy", if_req_ready, 0);
      chk("ls_ready_busy", ls_req_ready, 0);
      chk("mem_read", mem_read, (k == LAT) && !we);
      chk("mem_write", mem_write, (k == LAT) && we);
      if (k == LAT) begin
        chk("mem_raddr", mem_raddr, a);
        chk("mem_waddr", mem_waddr, a);
        if (we) begin
          chk("mem_wdata", mem_wdata, wd);
          chk("mem_wmask", mem_wmask, wm);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic round();
    bit exp_ls;
    @(negedge clk);
    if (!if_pend && !ls_pend) begin
      chk("idle_if_ready", if_req_ready, 0);
      chk("idle_ls_ready", ls_req_ready, 0);
      chk("idle_busy", busy, 0);
      @(posedge clk); #1;
      refill();
      return;
    end
    exp_ls = ls_pend && (!if_pend || ls_pri());
    chk("if_ready", if_req_ready, !exp_ls);
    chk("ls_ready", ls_req_ready, exp_ls);
    chk("busy_idle", busy, 0);
    run_txn(exp_ls);
    refill();
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_resp_valid || ls_resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", {if_resp_valid, ls_resp_valid}, 0);
        end else begin
          e = q.pop_front();
          chk("resp_if", if_resp_valid, !e.ls);
          chk("resp_ls", ls_resp_valid, e.ls);
          chk("resp_cycle", 64'(cyc), 64'(e.acc + LAT + 1));
          if (!e.we) begin
            if (e.ls) last_ls = e.rdata;
            else last_if = e.rdata;
          end
          chk("if_rdata", if_rdata, last_if);
          chk("ls_rdata", ls_rdata, last_ls);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boot fetch from the reset vector
    if_pend = 1;
    if_a = BASE;
    drive_inputs();
    round();

    // Sustained contention
    for (int i = 0; i < 4; i++) begin
      if (!if_pend) new_if();
      if (!ls_pend) new_ls();
      drive_inputs();
      round();
    end

    repeat (60) round();

    refill_en = 0;
    repeat (3) round();

    // Reset in the middle of an LS load
    if_pend = 0;
    ls_pend = 1;
    ls_we_v = 0;
    ls_a = rand_addr();
    drive_inputs();
    @(negedge clk);
    chk("rst_ls_ready", ls_req_ready, 1);
    @(posedge clk); #1;
    ls_pend = 0;
    drive_inputs();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_no_strobe", mem_read, 0);
    @(posedge clk); #1;
    model_reset();
    if_pend = 1;
    if_a = rand_addr();
    drive_inputs();
    @(negedge clk);
    chk_all_zero("abandon");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_if_ready", if_req_ready, 1);
    chk("post_rst_ls_ready", ls_req_ready, 0);
    run_txn(1'b0);
    drive_inputs();

    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single simulation memory port (DPI `pmem_read`/`pmem_write` path). It sits between instruction fetch (IF) and load/store unit (LS) and the memory blackbox. It accepts one request at a time over valid/ready, holds it for a fixed access latency, and strobes the memory port exactly once per transaction. It then returns a one-cycle response pulse to the winning requester.

## Interface
Parameters:
- `LAT`, default 1: access cycles per transaction; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `if_req_valid`  in  1  IF requests an instruction read.
- `if_req_ready`  out  1  IF request accepted this cycle when high together with valid.
- `if_addr`  in  64  IF read address (pc).
- `if_resp_valid`  out  1  one-cycle pulse; `if_rdata` is valid.
- `if_rdata`  out  64  fetched doubleword.
- `ls_req_valid`  in  1  LS request.
- `ls_req_ready`  out  1  LS request accepted.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  64  LS address.
- `ls_wdata`  in  64  store data.
- `ls_wmask`  in  8  store byte mask.
- `ls_resp_valid`  out  1  one-cycle pulse; load data valid, or store complete.
- `ls_rdata`  out  64  load data. Value is undefined-but-stable for stores: it holds the last read.
- `mem_raddr`  out  64  memory read address.
- `mem_read`  out  1  read strobe.
- `mem_waddr`  out  64  memory write address.
- `mem_wdata`  out  64  memory write data.
- `mem_wmask`  out  8  memory write mask.
- `mem_write`  out  1  write strobe.
- `mem_rdata`  in  64  combinational read data; valid in the same cycle as `mem_read`.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
FSM states are IDLE, ACCESS and RESP.

IDLE:
- Grant is computed combinationally from the valids.
- Exactly one of `if_req_ready`/`ls_req_ready` is high, and only if its valid is high. Both readies are low when no valid is high.
- On valid&ready: latch the winner ID, address, `we`, `wdata` and `wmask`. Load `cnt = LAT-1` and go to ACCESS.

ACCESS:
- The latched address drives `mem_raddr` and `mem_waddr`; the latched data and mask drive `mem_wdata` and `mem_wmask`.
- When `cnt != 0`: decrement, with no strobe.
- When `cnt == 0`: assert `mem_read` (if `!we`) or `mem_write` (if `we`) for exactly this cycle. If reading, capture `mem_rdata` into the winner's rdata register. Go to RESP.

RESP:
- Assert the winner's `*_resp_valid` for one cycle; there is no backpressure.
- Go to IDLE.

Datapath rules:
- `if_rdata` and `ls_rdata` are separate registers. Each holds its value until that requester's next read completes.
- IF requests are always reads. `ls_we`, `ls_wdata` and `ls_wmask` are ignored for IF.
- A store with `wmask == 0` still performs its `mem_write` strobe and its response pulse.
- Addresses are passed through unaligned and unmodified.
- Requests presented while `busy` are not accepted (ready = 0). Requesters must hold valid and payload stable until accepted.
- Arbitration when both are valid in IDLE: LS wins (fixed priority), unless round-robin is enabled (see Configuration).

## Timing
- Request accepted in cycle 0. ACCESS occupies cycles 1..LAT. The strobe is in cycle LAT. `resp_valid` is in cycle LAT+1. IDLE resumes in cycle LAT+2.
- Throughput is one transaction per LAT+2 cycles.
- The earliest next ready is cycle LAT+2, which is also the cycle after `resp_valid`.

Reset values (`rst_n` low at a clock edge):
- FSM = IDLE, `cnt = 0`.
- `busy`, `mem_read`, `mem_write` and both `resp_valid` = 0.
- Latched addr/data/mask = 0, so `mem_raddr`, `mem_waddr`, `mem_wdata` and `mem_wmask` are all 0.
- `if_rdata` = `ls_rdata` = 0.
- Round-robin pointer = IF-last.

Reset during ACCESS or RESP abandons the transaction: no strobe, no response pulse. While `rst_n` is low, both readies are 0.

Strobe outputs `mem_read` and `mem_write` are combinational decodes of registered state. They are never both high.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A `last_grant` register is updated on each accept.
  - On contention, the requester not granted last wins.
  - After reset, `last_grant = IF`, so the first contention goes to LS.
- `MEM_ARB_RR_EN` undefined: fixed priority, LS over IF. No `last_grant` register exists.

## Test plan
- LAT=1, IF read only. `if_addr = 0x80000000`, memory holds `0x00100073` there. Required: `if_req_ready` in cycle 0, `mem_read = 1` in cycle 1 only, `if_resp_valid` with `if_rdata = 0x00100073` in cycle 2, `busy` low in cycle 3.
- LAT=3, LS store. `addr = 0x80001000`, `wdata = 0x1122334455667788`, `wmask = 0x0F`. Required: `mem_write` in cycle 3 only, `mem_read` never, `ls_resp_valid` in cycle 4, readback load returns `0x0000000055667788` when memory was previously 0.
- Both valid every cycle, 4 transactions, fixed-priority build. Required: all 4 grants to LS and IF starved. RR build: grants alternate LS, IF, LS, IF.
- `rst_n` low in cycle 2 of a LAT=3 LS load. Required: no `mem_read` strobe, no `ls_resp_valid`, all outputs 0 from the next cycle, and a new IF request is accepted in the first cycle after `rst_n` returns high.
- IF valid raised while an LS transaction is busy. Required: `if_req_ready = 0` until the cycle after `ls_resp_valid`, then accepted. `if_rdata` unchanged by the LS load.
